// File: rtl/multicycle_controller.sv
// Main control FSM of the 16-bit multicycle core: sequences fetch/decode/execute/memory/writeback
// and drives ALU selects and datapath strobes. It also watches memory handshakes for bus timeouts.
module multicycle_controller #(
    parameter int unsigned PC_INC     = 2,
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic [2:0] funct,
    input  logic       zero,
    input  logic       less,
    input  logic       greater,
    input  logic       mem_ready,
    output logic [2:0] ALUControl,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       pc_src,
    output logic       pc_write,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       halted,
    output logic       bus_error,
    output logic       illegal
);

    typedef enum logic [3:0] {
        StIdle, StFetch, StDecode, StExecR, StExecI, StWbAlu, StMemAddr, StMemRd,
        StMemWr, StWbMem, StBranch, StJump, StHalt, StIllegal, StBusErr
    } state_e;

    localparam logic [3:0] OpR    = 4'h0;
    localparam logic [3:0] OpAddi = 4'h1;
    localparam logic [3:0] OpLw   = 4'h2;
    localparam logic [3:0] OpSw   = 4'h3;
    localparam logic [3:0] OpBeq  = 4'h4;
    localparam logic [3:0] OpBlt  = 4'h5;
    localparam logic [3:0] OpBge  = 4'h6;
    localparam logic [3:0] OpJal  = 4'h7;
    localparam logic [3:0] OpHalt = 4'hF;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluSlt = 3'b101;
    localparam logic [2:0] AluSrt = 3'b110;

    localparam logic [7:0] WaitLast = 8'(WAIT_LIMIT - 1);

    if (WAIT_LIMIT < 1 || WAIT_LIMIT > 255 || PC_INC == 0) begin : g_bad_param
        $error("multicycle_controller: WAIT_LIMIT must be 1..255 and PC_INC nonzero");
    end

    state_e     state_q;
    logic [7:0] wait_q;
    logic       wait_expired;
    logic [7:0] wait_inc;

    // Timeout fires on the WAIT_LIMIT-th cycle without mem_ready; a late ready still wins.
    assign wait_expired = !mem_ready && (wait_q >= WaitLast);
    assign wait_inc     = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            wait_q  <= '0;
        end else begin
            // Counter only survives while a memory state is stalled, so it is clear on entry.
            wait_q <= '0;
            case (state_q)
                StIdle: state_q <= StFetch;
                StFetch: begin
                    if (mem_ready)         state_q <= StDecode;
                    else if (wait_expired) state_q <= StBusErr;
                    else                   wait_q  <= wait_inc;
                end
                StDecode: begin
                    case (opcode)
                        OpR:                 state_q <= StExecR;
                        OpAddi:              state_q <= StExecI;
                        OpLw, OpSw:          state_q <= StMemAddr;
                        OpBeq, OpBlt, OpBge: state_q <= StBranch;
                        OpJal:               state_q <= StJump;
                        OpHalt:              state_q <= StHalt;
                        default:             state_q <= StIllegal;
                    endcase
                end
                StExecR, StExecI: state_q <= StWbAlu;
                StWbAlu:          state_q <= StFetch;
                StMemAddr:        state_q <= (opcode == OpLw) ? StMemRd : StMemWr;
                StMemRd: begin
                    if (mem_ready)         state_q <= StWbMem;
                    else if (wait_expired) state_q <= StBusErr;
                    else                   wait_q  <= wait_inc;
                end
                StMemWr: begin
                    if (mem_ready)         state_q <= StFetch;
                    else if (wait_expired) state_q <= StBusErr;
                    else                   wait_q  <= wait_inc;
                end
                StWbMem, StBranch, StJump: state_q <= StFetch;
                default: state_q <= state_q;
            endcase
        end
    end

    always_comb begin
        ALUControl = AluAdd;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        pc_src     = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;
        bus_error  = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            StFetch: begin
                mem_read = 1'b1;
                ALUSrcB  = 2'b01;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            StDecode: ALUSrcB = 2'b10;
            StExecR: begin
                ALUSrcA    = 1'b1;
                ALUControl = (funct == 3'b111) ? AluAdd : funct;
            end
            StExecI, StMemAddr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            StWbAlu: reg_write = 1'b1;
            StMemRd: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            StMemWr: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            StWbMem: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            StBranch: begin
                ALUSrcA = 1'b1;
                pc_src  = 1'b1;
                case (opcode)
                    OpBlt: begin
                        ALUControl = AluSlt;
                        pc_write   = less;
                    end
                    OpBge: begin
                        ALUControl = AluSrt;
                        pc_write   = greater;
                    end
                    default: begin
                        ALUControl = AluSub;
                        pc_write   = zero;
                    end
                endcase
            end
            StJump: begin
                pc_src    = 1'b1;
                pc_write  = 1'b1;
                reg_write = 1'b1;
            end
            StHalt:    halted    = 1'b1;
            StIllegal: illegal   = 1'b1;
            StBusErr:  bus_error = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a per-cycle vector table plus hand-written
// sequences for bus timeout and asynchronous reset during a memory write.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic [2:0] funct;
    logic       zero, less, greater, mem_ready;
    logic [2:0] ALUControl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       pc_src, pc_write, ir_write, iord, mem_read, mem_write;
    logic       reg_write, mem_to_reg, halted, bus_error, illegal;

    multicycle_controller #(.PC_INC(2), .WAIT_LIMIT(15)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .less(less),
        .greater(greater), .mem_ready(mem_ready), .ALUControl(ALUControl), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .pc_src(pc_src), .pc_write(pc_write), .ir_write(ir_write),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .halted(halted), .bus_error(bus_error), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [16:0] got;
    assign got = {ALUControl, ALUSrcA, ALUSrcB, pc_src, pc_write, ir_write, iord, mem_read,
                  mem_write, reg_write, mem_to_reg, halted, bus_error, illegal};

    typedef struct {
        logic        rst;
        logic [3:0]  op;
        logic [2:0]  fn;
        logic        z, l, g, rdy;
        logic [16:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;
    logic       c_rst;
    logic [3:0] c_op;
    logic [2:0] c_fn;
    logic       c_z, c_l, c_g;

    function automatic logic [16:0] mk(input logic [2:0] alu, input logic a, input logic [1:0] b,
                                       input logic pcs, pcw, irw, io, mr, mw, rw, m2r, h, be, il);
        return {alu, a, b, pcs, pcw, irw, io, mr, mw, rw, m2r, h, be, il};
    endfunction

    function automatic logic [16:0] e_fetch(input logic r);
        return mk(3'b000, 0, 2'b01, 0, r, r, 0, 1, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [16:0] e_exec_r(input logic [2:0] alu);
        return mk(alu, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [16:0] e_branch(input logic [2:0] alu, input logic pcw);
        return mk(alu, 1, 2'b00, 1, pcw, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    logic [16:0] e_idle, e_decode, e_exec_i, e_wb_alu, e_mem_rd, e_mem_wr, e_wb_mem;
    logic [16:0] e_jump, e_halt, e_ill, e_berr;

    task automatic setin(input logic r, input logic [3:0] op, input logic [2:0] fn,
                         input logic z, input logic l, input logic g);
        c_rst = r; c_op = op; c_fn = fn; c_z = z; c_l = l; c_g = g;
    endtask

    task automatic add(input string name, input logic rdy, input logic [16:0] exp);
        vec_t v;
        v.rst = c_rst; v.op = c_op; v.fn = c_fn; v.z = c_z; v.l = c_l; v.g = c_g;
        v.rdy = rdy; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [16:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%05h expected=%05h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance one clock.
    task automatic apply(input vec_t v);
        rst = v.rst; opcode = v.op; funct = v.fn; zero = v.z; less = v.l; greater = v.g;
        mem_ready = v.rdy;
        #1;
        check(v.name, v.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string name, input logic rdy, input logic [16:0] exp);
        vec_t v;
        v.rst = c_rst; v.op = c_op; v.fn = c_fn; v.z = c_z; v.l = c_l; v.g = c_g;
        v.rdy = rdy; v.exp = exp; v.name = name;
        apply(v);
    endtask

    initial begin
        e_idle   = '0;
        e_decode = mk(3'b000, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_exec_i = mk(3'b000, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e_wb_alu = mk(3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        e_mem_rd = mk(3'b000, 0, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        e_mem_wr = mk(3'b000, 0, 2'b00, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        e_wb_mem = mk(3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        e_jump   = mk(3'b000, 0, 2'b00, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        e_halt   = mk(3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        e_ill    = mk(3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        e_berr   = mk(3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        setin(1, 4'h0, 3'b001, 0, 0, 0); add("reset", 1, e_idle);
        setin(0, 4'h0, 3'b001, 0, 0, 0);
        add("r_idle", 1, e_idle);       add("r_fetch", 1, e_fetch(1));
        add("r_decode", 1, e_decode);   add("r_exec_sub", 1, e_exec_r(3'b001));
        add("r_wb", 1, e_wb_alu);
        setin(0, 4'h0, 3'b111, 0, 0, 0);
        add("r7_fetch", 1, e_fetch(1)); add("r7_decode", 1, e_decode);
        add("r7_exec_add", 1, e_exec_r(3'b000)); add("r7_wb", 1, e_wb_alu);
        setin(0, 4'h0, 3'b100, 0, 0, 0);
        add("rx_fetch", 1, e_fetch(1)); add("rx_decode", 1, e_decode);
        add("rx_exec_xor", 1, e_exec_r(3'b100)); add("rx_wb", 1, e_wb_alu);
        setin(0, 4'h1, 3'b011, 0, 0, 0);
        add("addi_fetch", 1, e_fetch(1)); add("addi_decode", 1, e_decode);
        add("addi_exec", 1, e_exec_i);   add("addi_wb", 1, e_wb_alu);
        setin(0, 4'h2, 3'b000, 0, 0, 0);
        add("lw_fetch", 1, e_fetch(1));  add("lw_decode", 1, e_decode);
        add("lw_addr", 1, e_exec_i);
        add("lw_rd_wait1", 0, e_mem_rd); add("lw_rd_wait2", 0, e_mem_rd);
        add("lw_rd_wait3", 0, e_mem_rd); add("lw_rd_done", 1, e_mem_rd);
        add("lw_wb", 1, e_wb_mem);
        setin(0, 4'h3, 3'b000, 0, 0, 0);
        add("sw_fetch_wait1", 0, e_fetch(0)); add("sw_fetch_wait2", 0, e_fetch(0));
        add("sw_fetch", 1, e_fetch(1));  add("sw_decode", 1, e_decode);
        add("sw_addr", 1, e_exec_i);     add("sw_wr", 1, e_mem_wr);
        setin(0, 4'h4, 3'b000, 1, 0, 0);
        add("beq_fetch", 1, e_fetch(1)); add("beq_decode", 1, e_decode);
        add("beq_taken", 1, e_branch(3'b001, 1));
        setin(0, 4'h4, 3'b000, 0, 1, 1);
        add("beq2_fetch", 1, e_fetch(1)); add("beq2_decode", 1, e_decode);
        add("beq_not_taken", 1, e_branch(3'b001, 0));
        setin(0, 4'h5, 3'b000, 1, 0, 1);
        add("blt_fetch", 1, e_fetch(1)); add("blt_decode", 1, e_decode);
        add("blt_not_taken", 1, e_branch(3'b101, 0));
        setin(0, 4'h6, 3'b000, 0, 0, 1);
        add("bge_fetch", 1, e_fetch(1)); add("bge_decode", 1, e_decode);
        add("bge_taken", 1, e_branch(3'b110, 1));
        setin(0, 4'h7, 3'b000, 0, 0, 0);
        add("jal_fetch", 1, e_fetch(1)); add("jal_decode", 1, e_decode);
        add("jal_jump", 1, e_jump);      add("jal_next_fetch", 0, e_fetch(0));
        setin(0, 4'hA, 3'b000, 0, 0, 0);
        add("ill_fetch", 1, e_fetch(1)); add("ill_decode", 1, e_decode);
        add("ill_state", 1, e_ill);      add("ill_sticky", 1, e_ill);
        setin(1, 4'hA, 3'b000, 0, 0, 0); add("ill_cleared", 1, e_idle);
        setin(0, 4'hF, 3'b000, 0, 0, 0);
        add("h_idle", 1, e_idle);        add("h_fetch", 1, e_fetch(1));
        add("h_decode", 1, e_decode);    add("h_state", 1, e_halt);
        add("h_sticky", 0, e_halt);
        setin(1, 4'hF, 3'b000, 0, 0, 0); add("h_cleared", 1, e_idle);

        rst = 1'b1; opcode = '0; funct = '0; zero = 0; less = 0; greater = 0; mem_ready = 0;
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Fetch timeout: fifteen stalled cycles, then terminal bus error.
        setin(1, 4'h0, 3'b000, 0, 0, 0); step("be_rst", 0, e_idle);
        setin(0, 4'h0, 3'b000, 0, 0, 0); step("be_idle", 0, e_idle);
        for (int i = 0; i < 15; i++) step("be_fetch_wait", 0, e_fetch(0));
        step("be_error", 0, e_berr);
        step("be_sticky", 1, e_berr);

        // Ready arriving on the fifteenth cycle completes normally.
        setin(1, 4'h0, 3'b000, 0, 0, 0); step("lim_rst", 0, e_idle);
        setin(0, 4'h0, 3'b000, 0, 0, 0); step("lim_idle", 0, e_idle);
        for (int i = 0; i < 14; i++) step("lim_fetch_wait", 0, e_fetch(0));
        step("lim_fetch_ready", 1, e_fetch(1));
        step("lim_no_error", 1, e_decode);

        // Timeout inside a data read.
        setin(0, 4'h2, 3'b000, 0, 0, 0);
        step("rdto_exec", 1, e_exec_r(3'b000));
        step("rdto_wb", 1, e_wb_alu);
        step("rdto_fetch", 1, e_fetch(1));
        step("rdto_decode", 1, e_decode);
        step("rdto_addr", 1, e_exec_i);
        for (int i = 0; i < 15; i++) step("rdto_wait", 0, e_mem_rd);
        step("rdto_error", 0, e_berr);

        // Asynchronous reset while a write is pending.
        setin(1, 4'h3, 3'b000, 0, 0, 0); step("mw_rst", 1, e_idle);
        setin(0, 4'h3, 3'b000, 0, 0, 0);
        step("mw_idle", 1, e_idle);
        step("mw_fetch", 1, e_fetch(1));
        step("mw_decode", 1, e_decode);
        step("mw_addr", 1, e_exec_i);
        rst = 1'b0; mem_ready = 1'b0;
        #1 check("mw_pending", e_mem_wr);
        rst = 1'b1;
        #1 check("mw_async_drop", e_idle);
        @(posedge clk); #1;
        rst = 1'b0;
        #1 check("mw_released_idle", e_idle);
        @(posedge clk); #1;
        check("mw_refetch", e_fetch(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
